piso_right_tx: RTL

//  Parallel-in serial-out transmitter; the sending end of the right-shifting SIPO link.

---
 rtl/piso_right_tx_pkg.sv | 15 +
 rtl/piso_right_tx_clk_en_div.sv | 32 +++
 rtl/piso_right_tx.sv | 94 +++++++++
 3 files changed

// File: rtl/piso_right_tx_pkg.sv
// Shared definitions for the PISO transmitter: FSM encoding and counter width helper.
package piso_right_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Counter width for a terminal value of n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_right_tx_clk_en_div.sv
// Bit-period divider: counts clk cycles within one serial bit and flags the last one.
module clk_en_div
  import piso_right_tx_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Restarts at zero after the terminal count so it never runs past DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= tc ? '0 : div_cnt + CW'(1);
    end
  end

  assign tc = (div_cnt == LAST);

endmodule

// File: rtl/piso_right_tx.sv
// Parallel-in serial-out transmitter, LSB first, with per-bit strobe and end-of-frame latch pulse.
module piso_right_tx
  import piso_right_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   CLK_DIV    = 1,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  bit_strobe,
  output logic                  latch_pulse,
  output logic                  busy
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state;
  // Only the bits not yet on serial_out are kept; bit 0 goes straight to the output register.
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] shift_word;
  logic [BW-1:0]         bit_cnt;
  logic                  period_end;
  logic                  accept;
  logic                  shifting;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = load_valid && load_ready;
  assign shifting   = (state == ST_SHIFT);
  assign bit_strobe = shifting && period_end;
  assign shift_word = {IDLE_VALUE, shreg};

  clk_en_div #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(shifting),
    .tc    (period_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      serial_out  <= IDLE_VALUE;
      shreg       <= '0;
      bit_cnt     <= '0;
      latch_pulse <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          latch_pulse <= 1'b0;
          serial_out  <= IDLE_VALUE;
          if (load_valid) begin
            shreg      <= load_data[DATA_WIDTH-1:1];
            serial_out <= load_data[0];
            bit_cnt    <= '0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (period_end) begin
            if (bit_cnt != LAST_BIT) begin
              shreg      <= shift_word[DATA_WIDTH-1:1];
              serial_out <= shift_word[0];
              bit_cnt    <= bit_cnt + BW'(1);
            end else begin
              state       <= ST_LATCH;
              serial_out  <= IDLE_VALUE;
              latch_pulse <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          state       <= ST_IDLE;
          latch_pulse <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          serial_out  <= IDLE_VALUE;
          latch_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule
